// File: rtl/acs_pm_bank_if.sv
// Symbol-in / decision-out bundle between the metric adder, the ACS bank and the
// traceback memory.
interface acs_pm_bank_if #(
  parameter int PM_W = 6
) ();
  logic              in_valid;
  logic              start;
  logic [1:0]        sym;
  logic              dec_valid;
  logic [3:0]        dec;
  logic [1:0]        best_state;
  logic [4*PM_W-1:0] pm_flat;
  logic              norm_evt;

  modport master (
    output in_valid, start, sym,
    input  dec_valid, dec, best_state, pm_flat, norm_evt
  );

  modport slave (
    input  in_valid, start, sym,
    output dec_valid, dec, best_state, pm_flat, norm_evt
  );
endinterface

// File: rtl/acs_pm_bank.sv
// Add-compare-select with a four-state path-metric bank for the K=3 (7,5) hard-decision
// Viterbi decoder: saturating adds, survivor bits, normalization and best-state index.
module acs_pm_bank #(
  parameter int PM_W      = 6,
  parameter int INIT_BIAS = 16,
  parameter int NORM_THR  = 32
) (
  input  logic         clk,
  input  logic         reset,
  acs_pm_bank_if.slave bus
);

  localparam logic [PM_W-1:0] PM_MAX = '1;
  localparam logic [PM_W-1:0] BIAS   = PM_W'(INIT_BIAS);
  localparam logic [PM_W-1:0] THR    = PM_W'(NORM_THR);

  logic [PM_W-1:0] pm_reg [4];
  logic [PM_W-1:0] old_pm [4];
  logic [PM_W-1:0] sel_pm [4];
  logic [PM_W-1:0] pm_next [4];
  logic [3:0]      dec_next;
  logic [3:0]      dec_reg;
  logic [1:0]      best_reg;
  logic [1:0]      best_next;
  logic            dec_valid_reg;
  logic            norm_reg;
  logic            norm_hit;
  logic [PM_W-1:0] min_pm;

  // The first symbol of a frame sees the initial vector, not the stale bank.
  always_comb begin
    old_pm[0] = bus.start ? '0   : pm_reg[0];
    old_pm[1] = bus.start ? BIAS : pm_reg[1];
    old_pm[2] = bus.start ? BIAS : pm_reg[2];
    old_pm[3] = bus.start ? BIAS : pm_reg[3];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_acs
      // Next state n = {u, n0}; predecessors are {n0, x} for x = 0/1.
      localparam bit U  = bit'((gi >> 1) & 1);
      localparam bit N0 = bit'(gi & 1);
      localparam bit C0_X0 = U ^ N0;
      localparam bit C1_X0 = U;
      localparam bit C0_X1 = U ^ N0 ^ 1'b1;
      localparam bit C1_X1 = U ^ 1'b1;

      logic [1:0]      bm0, bm1;
      logic [PM_W:0]   sum0, sum1;
      logic [PM_W-1:0] cand0, cand1;

      assign bm0   = 2'(bus.sym[1] ^ C0_X0) + 2'(bus.sym[0] ^ C1_X0);
      assign bm1   = 2'(bus.sym[1] ^ C0_X1) + 2'(bus.sym[0] ^ C1_X1);
      assign sum0  = {1'b0, old_pm[2*N0]}     + (PM_W+1)'(bm0);
      assign sum1  = {1'b0, old_pm[2*N0 + 1]} + (PM_W+1)'(bm1);
      assign cand0 = sum0[PM_W] ? PM_MAX : sum0[PM_W-1:0];
      assign cand1 = sum1[PM_W] ? PM_MAX : sum1[PM_W-1:0];

      // Strict compare so a tie keeps the x = 0 predecessor.
      assign dec_next[gi] = (cand1 < cand0);
      assign sel_pm[gi]   = (cand1 < cand0) ? cand1 : cand0;
    end
  endgenerate

  always_comb begin
    min_pm = sel_pm[0];
    for (int i = 1; i < 4; i++) begin
      if (sel_pm[i] < min_pm) min_pm = sel_pm[i];
    end
    norm_hit = (min_pm >= THR);
    for (int i = 0; i < 4; i++) begin
      pm_next[i] = norm_hit ? (sel_pm[i] - THR) : sel_pm[i];
    end
  end

  // Lowest index wins on equal metrics.
  always_comb begin
    best_next = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (pm_next[i] < pm_next[best_next]) best_next = 2'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pm_reg[0]     <= '0;
      pm_reg[1]     <= BIAS;
      pm_reg[2]     <= BIAS;
      pm_reg[3]     <= BIAS;
      dec_reg       <= '0;
      best_reg      <= '0;
      dec_valid_reg <= 1'b0;
      norm_reg      <= 1'b0;
    end else if (bus.in_valid) begin
      for (int i = 0; i < 4; i++) pm_reg[i] <= pm_next[i];
      dec_reg       <= dec_next;
      best_reg      <= best_next;
      dec_valid_reg <= 1'b1;
      norm_reg      <= norm_hit;
    end else begin
      dec_valid_reg <= 1'b0;
      if (bus.start) begin
        pm_reg[0] <= '0;
        pm_reg[1] <= BIAS;
        pm_reg[2] <= BIAS;
        pm_reg[3] <= BIAS;
        dec_reg   <= '0;
        best_reg  <= '0;
        norm_reg  <= 1'b0;
      end
    end
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : g_flat
      assign bus.pm_flat[gi*PM_W +: PM_W] = pm_reg[gi];
    end
  endgenerate

  assign bus.dec        = dec_reg;
  assign bus.best_state = best_reg;
  assign bus.dec_valid  = dec_valid_reg;
  assign bus.norm_evt   = norm_reg;

endmodule

// File: tb/tb_acs_pm_bank.sv
// Randomized and directed check of acs_pm_bank in three parameterizations against a
// trellis-walking reference model.
module tb_acs_pm_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iv = 1'b0;
  logic       st = 1'b0;
  logic [1:0] sy = 2'b00;

  always #5 clk = ~clk;

  acs_pm_bank_if #(.PM_W(6)) if0 ();
  acs_pm_bank_if #(.PM_W(6)) if1 ();
  acs_pm_bank_if #(.PM_W(6)) if2 ();

  assign if0.in_valid = iv; assign if0.start = st; assign if0.sym = sy;
  assign if1.in_valid = iv; assign if1.start = st; assign if1.sym = sy;
  assign if2.in_valid = iv; assign if2.start = st; assign if2.sym = sy;

  acs_pm_bank #(.PM_W(6), .INIT_BIAS(16), .NORM_THR(32)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  acs_pm_bank #(.PM_W(6), .INIT_BIAS(16), .NORM_THR(1))  dut1 (.clk(clk), .reset(reset), .bus(if1));
  acs_pm_bank #(.PM_W(6), .INIT_BIAS(63), .NORM_THR(32)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  int pm_o [3];
  int dec_o [3];
  int best_o [3];
  int dv_o [3];
  int norm_o [3];

  always_comb begin
    pm_o[0] = int'(if0.pm_flat); dec_o[0] = int'(if0.dec); best_o[0] = int'(if0.best_state);
    dv_o[0] = int'(if0.dec_valid); norm_o[0] = int'(if0.norm_evt);
    pm_o[1] = int'(if1.pm_flat); dec_o[1] = int'(if1.dec); best_o[1] = int'(if1.best_state);
    dv_o[1] = int'(if1.dec_valid); norm_o[1] = int'(if1.norm_evt);
    pm_o[2] = int'(if2.pm_flat); dec_o[2] = int'(if2.dec); best_o[2] = int'(if2.best_state);
    dv_o[2] = int'(if2.dec_valid); norm_o[2] = int'(if2.norm_evt);
  end

  // Reference model state per instance.
  int thr_m [3]  = '{32, 1, 32};
  int bias_m [3] = '{16, 16, 63};
  int pm_m [3][4];
  int dec_m [3];
  int best_m [3];
  int dv_m [3];
  int norm_m [3];

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pack4(input int a, input int b, input int c, input int d);
    return a | (b << 6) | (c << 12) | (d << 18);
  endfunction

  function automatic int parity3(input int v);
    return ((v >> 2) ^ (v >> 1) ^ v) & 1;
  endfunction

  function automatic int argmin4(input int a0, input int a1, input int a2, input int a3);
    int v [4];
    int b;
    v = '{a0, a1, a2, a3};
    b = 0;
    for (int i = 1; i < 4; i++) if (v[i] < v[b]) b = i;
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      pm_m[k] = '{0, bias_m[k], bias_m[k], bias_m[k]};
      dec_m[k] = 0; best_m[k] = 0; dv_m[k] = 0; norm_m[k] = 0;
    end
  endtask

  // Walk every (state, input) edge of the trellis and keep the best arrival per state.
  task automatic model_step(input int k, input bit v, input bit s, input int sym);
    int old [4];
    int nw [4];
    int d, mn, n, reg3, c0, c1, bm, cand;
    if (!v) begin
      dv_m[k] = 0;
      if (s) begin
        pm_m[k] = '{0, bias_m[k], bias_m[k], bias_m[k]};
        dec_m[k] = 0; best_m[k] = 0; norm_m[k] = 0;
      end
      return;
    end
    old = s ? '{0, bias_m[k], bias_m[k], bias_m[k]} : pm_m[k];
    nw = '{1000, 1000, 1000, 1000};
    d = 0;
    for (int st_i = 0; st_i < 4; st_i++) begin
      for (int u = 0; u < 2; u++) begin
        n = u * 2 + (st_i >> 1);
        reg3 = (u << 2) | st_i;
        c0 = parity3(reg3 & 7);
        c1 = parity3(reg3 & 5);
        bm = (((sym >> 1) & 1) != c0 ? 1 : 0) + ((sym & 1) != c1 ? 1 : 0);
        cand = old[st_i] + bm;
        if (cand > 63) cand = 63;
        if (cand < nw[n]) begin
          nw[n] = cand;
          if ((st_i & 1) == 1) d = d | (1 << n);
          else d = d & ~(1 << n);
        end
      end
    end
    mn = nw[0];
    for (int i = 1; i < 4; i++) if (nw[i] < mn) mn = nw[i];
    norm_m[k] = (mn >= thr_m[k]) ? 1 : 0;
    if (norm_m[k] == 1) for (int i = 0; i < 4; i++) nw[i] -= thr_m[k];
    pm_m[k] = nw;
    dec_m[k] = d;
    best_m[k] = argmin4(nw[0], nw[1], nw[2], nw[3]);
    dv_m[k] = 1;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.u%0d.pm", tag, k), pm_o[k], pack4(pm_m[k][0], pm_m[k][1], pm_m[k][2], pm_m[k][3]));
      chk($sformatf("%s.u%0d.dec", tag, k), dec_o[k], dec_m[k]);
      chk($sformatf("%s.u%0d.best", tag, k), best_o[k], best_m[k]);
      chk($sformatf("%s.u%0d.dv", tag, k), dv_o[k], dv_m[k]);
      chk($sformatf("%s.u%0d.norm", tag, k), norm_o[k], norm_m[k]);
    end
  endtask

  task automatic do_cycle(input string tag, input bit v, input bit s, input logic [1:0] sym);
    iv = v; st = s; sy = sym;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) model_step(k, v, s, int'(sym));
    check_all(tag);
    $display("cyc %s iv=%0b st=%0b sym=%0b pm0=%06h dec0=%0h best0=%0d", tag, v, s, sym, pm_o[0], dec_o[0], best_o[0]);
  endtask

  task automatic do_reset(input string tag);
    iv = 0; st = 0; sy = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_all(tag);
  endtask

  logic [1:0] gap_syms [6] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01};

  initial begin
    model_reset();
    #2;
    do_reset("rst");

    // Test-plan vectors.
    do_cycle("tp_s00", 1, 0, 2'b00);
    chk("tp_s00.pm_dflt", pm_o[0], pack4(0, 17, 2, 17));
    chk("tp_s00.pm_sat", pm_o[2], pack4(0, 63, 2, 63));
    chk("tp_s00.dec_sat", dec_o[2], 0);
    do_cycle("tp_s11", 1, 0, 2'b11);
    chk("tp_s11.pm", pm_o[0], pack4(2, 3, 0, 3));
    chk("tp_s11.best", best_o[0], 2);

    do_reset("rst2");
    do_cycle("nt_1", 1, 0, 2'b11);
    chk("nt_1.pm", pm_o[1], pack4(2, 17, 0, 17));
    do_cycle("nt_2", 1, 0, 2'b11);
    chk("nt_2.pm", pm_o[1], pack4(3, 0, 1, 0));
    chk("nt_2.norm", norm_o[1], 1);
    do_cycle("nt_3", 1, 0, 2'b11);
    chk("nt_3.pm", pm_o[1], pack4(0, 1, 2, 1));
    chk("nt_3.dec", dec_o[1], 15);
    chk("nt_3.norm", norm_o[1], 0);

    // Idle start reloads the initial vector.
    do_cycle("st_idle", 0, 1, 2'b10);
    chk("st_idle.pm", pm_o[0], pack4(0, 16, 16, 16));
    chk("st_idle.dv", dv_o[0], 0);

    // Gapped stream: three idle cycles between symbols.
    for (int i = 0; i < 6; i++) begin
      do_cycle($sformatf("gap_sym%0d", i), 1, (i == 0), gap_syms[i]);
      for (int g = 0; g < 3; g++) do_cycle($sformatf("gap_idle%0d_%0d", i, g), 0, 0, 2'(g));
    end

    // Asynchronous reset landing between edges.
    do_cycle("pre_arst", 1, 0, 2'b11);
    iv = 1; st = 0; sy = 2'b10;
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    @(posedge clk);
    #1;
    check_all("arst_hold");
    reset = 1'b0;
    iv = 0;

    // Randomized stream.
    for (int i = 0; i < 400; i++) begin
      do_cycle($sformatf("rnd%0d", i), ($urandom % 4) != 0, ($urandom % 16) == 0, 2'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
